// File: rtl/stack_ctrl_if.sv
// ---------------------------------------------------------------------------
// stack_ctrl_if
// Request/response channel between a stack client and stack_ctrl.
//   req_valid  : request present (client -> controller)
//   req_ready  : controller can accept (controller -> client)
//   req_op     : 01 push, 10 pop, 11 top, 00 illegal
//   req_data   : push value
//   resp_valid : one-cycle response pulse
//   resp_data  : popped/top value, 0 for push or error
//   resp_err   : overflow, underflow or illegal op, qualified by resp_valid
// Modports: master = client side, slave = controller side.
// ---------------------------------------------------------------------------
interface stack_ctrl_if #(
    parameter int M = 32
);
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [M-1:0] req_data;
    logic         resp_valid;
    logic [M-1:0] resp_data;
    logic         resp_err;

    modport master (
        output req_valid, req_op, req_data,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl
// Stack controller in front of a dual-port stack memory (asynchronous read,
// write on the falling clock edge while mem_beta is high). Accepts push, pop
// and top requests, owns the stack pointer, sequences the memory write enable
// and the read-settle wait, and returns exactly one response per request.
//
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : stack_ctrl_if.slave request/response channel
//   count        : current number of entries (IND_SIZE+1 bits)
//   full, empty  : count == N, count == 0
//   mem_in       : memory write data
//   mem_ind1     : memory write address
//   mem_ind2     : memory read address
//   mem_beta     : memory write enable
//   mem_out2     : memory read data
//
// Optional feature macro: STACK_CTRL_SCRUB_EN
//   When defined, a successful pop writes 0 into the freed entry in an extra
//   SCRUB cycle before the response.
// ---------------------------------------------------------------------------
module stack_ctrl #(
    parameter int N           = 1024,
    parameter int M           = 32,
    parameter int IND_SIZE    = $clog2(N),
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clock,
    input  logic                reset,
    stack_ctrl_if.slave         bus,
    output logic [IND_SIZE:0]   count,
    output logic                full,
    output logic                empty,
    output logic [M-1:0]        mem_in,
    output logic [IND_SIZE-1:0] mem_ind1,
    output logic [IND_SIZE-1:0] mem_ind2,
    output logic                mem_beta,
    input  logic [M-1:0]        mem_out2
);

    localparam logic [1:0]        OP_PUSH   = 2'b01;
    localparam logic [1:0]        OP_POP    = 2'b10;
    localparam logic [1:0]        OP_TOP    = 2'b11;
    localparam logic [IND_SIZE:0] CNT_ONE   = (IND_SIZE+1)'(1);
    localparam logic [IND_SIZE:0] CNT_ZERO  = (IND_SIZE+1)'(0);
    localparam logic [IND_SIZE:0] CNT_FULL  = (IND_SIZE+1)'(N);
    // Down-counter reload: READ_WAIT lasts WAIT_CYCLES cycles, ending on zero.
    localparam logic [3:0]        WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_READ_WAIT = 3'd2,
        ST_SCRUB     = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    state_t                state_r;
    logic [1:0]            op_r;
    logic [3:0]            wait_r;
    logic [IND_SIZE:0]     count_r;
    logic                  full_r;
    logic                  empty_r;
    logic [M-1:0]          mem_in_r;
    logic [IND_SIZE-1:0]   mem_ind1_r;
    logic [IND_SIZE-1:0]   mem_ind2_r;
    logic                  mem_beta_r;
    logic                  req_ready_r;
    logic                  resp_valid_r;
    logic [M-1:0]          resp_data_r;
    logic                  resp_err_r;
`ifdef STACK_CTRL_SCRUB_EN
    logic [M-1:0]          rd_data_r;
`endif

    logic [IND_SIZE:0]     count_inc_s;
    logic [IND_SIZE:0]     count_dec_s;

    // Neighbouring stack pointer values; only used where they cannot wrap.
    always_comb begin
        count_inc_s = count_r + CNT_ONE;
        count_dec_s = count_r - CNT_ONE;
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            op_r         <= 2'b00;
            wait_r       <= 4'd0;
            count_r      <= CNT_ZERO;
            full_r       <= 1'b0;
            empty_r      <= 1'b1;
            mem_in_r     <= '0;
            mem_ind1_r   <= '0;
            mem_ind2_r   <= '0;
            mem_beta_r   <= 1'b0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_data_r  <= '0;
            resp_err_r   <= 1'b0;
`ifdef STACK_CTRL_SCRUB_EN
            rd_data_r    <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        req_ready_r <= 1'b0;
                        op_r        <= bus.req_op;
                        case (bus.req_op)
                            OP_PUSH: begin
                                if (!full_r) begin
                                    // mem_ind1 already tracks count while idle.
                                    state_r    <= ST_WRITE;
                                    mem_beta_r <= 1'b1;
                                    mem_in_r   <= bus.req_data;
                                end else begin
                                    state_r      <= ST_RESP;
                                    resp_valid_r <= 1'b1;
                                    resp_err_r   <= 1'b1;
                                    resp_data_r  <= '0;
                                end
                            end
                            OP_POP, OP_TOP: begin
                                if (!empty_r) begin
                                    state_r    <= ST_READ_WAIT;
                                    mem_ind2_r <= count_dec_s[IND_SIZE-1:0];
                                    wait_r     <= WAIT_LOAD;
                                end else begin
                                    state_r      <= ST_RESP;
                                    resp_valid_r <= 1'b1;
                                    resp_err_r   <= 1'b1;
                                    resp_data_r  <= '0;
                                end
                            end
                            default: begin
                                state_r      <= ST_RESP;
                                resp_valid_r <= 1'b1;
                                resp_err_r   <= 1'b1;
                                resp_data_r  <= '0;
                            end
                        endcase
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end

                ST_WRITE: begin
                    mem_beta_r   <= 1'b0;
                    mem_in_r     <= '0;
                    count_r      <= count_inc_s;
                    mem_ind1_r   <= count_inc_s[IND_SIZE-1:0];
                    full_r       <= (count_inc_s == CNT_FULL);
                    empty_r      <= 1'b0;
                    state_r      <= ST_RESP;
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                    resp_data_r  <= '0;
                end

                ST_READ_WAIT: begin
                    if (wait_r == 4'd0) begin
                        if (op_r == OP_POP) begin
                            count_r    <= count_dec_s;
                            // After the decrement, count equals the freed slot.
                            mem_ind1_r <= count_dec_s[IND_SIZE-1:0];
                            full_r     <= 1'b0;
                            empty_r    <= (count_dec_s == CNT_ZERO);
`ifdef STACK_CTRL_SCRUB_EN
                            rd_data_r  <= mem_out2;
                            state_r    <= ST_SCRUB;
                            mem_beta_r <= 1'b1;
                            mem_in_r   <= '0;
`else
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b0;
                            resp_data_r  <= mem_out2;
`endif
                        end else begin
                            state_r      <= ST_RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b0;
                            resp_data_r  <= mem_out2;
                        end
                    end else begin
                        wait_r <= wait_r - 4'd1;
                    end
                end

`ifdef STACK_CTRL_SCRUB_EN
                ST_SCRUB: begin
                    mem_beta_r   <= 1'b0;
                    state_r      <= ST_RESP;
                    resp_valid_r <= 1'b1;
                    resp_err_r   <= 1'b0;
                    resp_data_r  <= rd_data_r;
                end
`endif

                ST_RESP: begin
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_data_r  <= '0;
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                end

                default: begin
                    // Unreachable encodings recover to a quiet IDLE.
                    state_r      <= ST_IDLE;
                    mem_beta_r   <= 1'b0;
                    mem_in_r     <= '0;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_data_r  <= '0;
                    req_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_data  = resp_data_r;
    assign bus.resp_err   = resp_err_r;
    assign count          = count_r;
    assign full           = full_r;
    assign empty          = empty_r;
    assign mem_in         = mem_in_r;
    assign mem_ind1       = mem_ind1_r;
    assign mem_ind2       = mem_ind2_r;
    assign mem_beta       = mem_beta_r;

endmodule

// File: tb/tb_stack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stack_ctrl
// Self-checking bench for stack_ctrl with N=4, WAIT_CYCLES=2. Includes a
// behavioural model of the stack memory (negedge write, delayed async read)
// and a queue-based reference stack. Build with +define+STACK_CTRL_SCRUB_EN
// to exercise the scrub variant.
// ---------------------------------------------------------------------------
module tb_stack_ctrl;
    localparam int N    = 4;
    localparam int M    = 32;
    localparam int IND  = 2;
    localparam int WAIT = 2;
`ifdef STACK_CTRL_SCRUB_EN
    localparam int SCRUB = 1;
`else
    localparam int SCRUB = 0;
`endif

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [IND:0]   count;
    logic           full;
    logic           empty;
    logic [M-1:0]   mem_in;
    logic [IND-1:0] mem_ind1;
    logic [IND-1:0] mem_ind2;
    logic           mem_beta;
    logic [M-1:0]   mem_out2;
    logic [M-1:0]   mem_arr [0:N-1];

    int checks   = 0;
    int failures = 0;
    logic [M-1:0] model_q [$];

    always #5 clock = ~clock;

    stack_ctrl_if #(.M(M)) bus ();

    stack_ctrl #(.N(N), .M(M), .IND_SIZE(IND), .WAIT_CYCLES(WAIT)) dut (
        .clock(clock), .reset(reset), .bus(bus),
        .count(count), .full(full), .empty(empty),
        .mem_in(mem_in), .mem_ind1(mem_ind1), .mem_ind2(mem_ind2),
        .mem_beta(mem_beta), .mem_out2(mem_out2)
    );

    // Stack memory model: falling-edge write, asynchronous read with delay.
    always @(negedge clock) if (mem_beta) mem_arr[mem_ind1] <= mem_in;
    assign #3 mem_out2 = mem_arr[mem_ind2];

    // Drive one request and observe the response and any memory writes.
    task automatic do_req(input logic [1:0] op, input logic [M-1:0] d,
                          output int lat, output logic [M-1:0] rd, output logic re,
                          output int beta_n, output int beta_addr, output logic [M-1:0] beta_din);
        lat = 0; rd = '0; re = 1'b0; beta_n = 0; beta_addr = -1; beta_din = '0;
        for (int w = 0; w < 10; w++) begin
            @(negedge clock);
            if (bus.req_ready === 1'b1) break;
        end
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_data = d;
        @(posedge clock);
        #1 bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_data = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (mem_beta === 1'b1) begin
                beta_n++; beta_addr = int'(mem_ind1); beta_din = mem_in;
            end
            if (bus.resp_valid === 1'b1) begin
                lat = i; rd = bus.resp_data; re = bus.resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        model_q.delete();
        checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, full, empty, mem_beta} !== 6'b100010) begin
            failures++;
            $display("FAIL reset_flags got rdy=%b rv=%b re=%b full=%b empty=%b beta=%b exp 1 0 0 0 1 0",
                     bus.req_ready, bus.resp_valid, bus.resp_err, full, empty, mem_beta);
        end
        checks++;
        if ({count, mem_ind1, mem_ind2, mem_in, bus.resp_data} !== '0) begin
            failures++;
            $display("FAIL reset_values got count=%0d ind1=%0d ind2=%0d in=%h rdata=%h exp all 0",
                     count, mem_ind1, mem_ind2, mem_in, bus.resp_data);
        end
    endtask

    task automatic test_push();
        int lat, bn, ba; logic [M-1:0] rd, bd; logic re;
        for (int i = 0; i < 2; i++) begin
            logic [M-1:0] d;
            d = 32'hA + 32'(i);
            do_req(2'b01, d, lat, rd, re, bn, ba, bd);
            model_q.push_back(d);
            checks++;
            if (lat !== 2 || re !== 1'b0 || bn !== 1 || ba !== i || bd !== d) begin
                failures++;
                $display("FAIL push_%0d got lat=%0d err=%b beta_n=%0d addr=%0d din=%h exp lat=2 err=0 beta_n=1 addr=%0d din=%h",
                         i, lat, re, bn, ba, bd, i, d);
            end
        end
        checks++;
        if (count !== 3'd2 || empty !== 1'b0) begin
            failures++;
            $display("FAIL push_count got count=%0d empty=%b exp 2 0", count, empty);
        end
    endtask

    task automatic test_top_pop();
        int lat, bn, ba; logic [M-1:0] rd, bd; logic re;
        do_req(2'b11, '0, lat, rd, re, bn, ba, bd);
        checks++;
        if (rd !== 32'hB || re !== 1'b0 || lat !== WAIT + 1 || bn !== 0 || count !== 3'd2) begin
            failures++;
            $display("FAIL top got data=%h err=%b lat=%0d beta_n=%0d count=%0d exp B 0 %0d 0 2",
                     rd, re, lat, bn, count, WAIT + 1);
        end
        for (int i = 0; i < 2; i++) begin
            logic [M-1:0] ed;
            ed = model_q.pop_back();
            do_req(2'b10, '0, lat, rd, re, bn, ba, bd);
            checks++;
            if (rd !== ed || re !== 1'b0 || lat !== WAIT + 1 + SCRUB || bn !== SCRUB) begin
                failures++;
                $display("FAIL pop_%0d got data=%h err=%b lat=%0d beta_n=%0d exp %h 0 %0d %0d",
                         i, rd, re, lat, bn, ed, WAIT + 1 + SCRUB, SCRUB);
            end
        end
        checks++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL pop_empty got count=%0d empty=%b exp 0 1", count, empty);
        end
    endtask

    task automatic test_empty_err();
        int lat, bn, ba; logic [M-1:0] rd, bd; logic re;
        do_req(2'b10, '0, lat, rd, re, bn, ba, bd);
        checks++;
        if (re !== 1'b1 || rd !== '0 || lat !== 1 || bn !== 0 || count !== 3'd0) begin
            failures++;
            $display("FAIL underflow got err=%b data=%h lat=%0d beta_n=%0d count=%0d exp 1 0 1 0 0",
                     re, rd, lat, bn, count);
        end
        do_req(2'b00, 32'h77, lat, rd, re, bn, ba, bd);
        checks++;
        if (re !== 1'b1 || rd !== '0 || lat !== 1 || bn !== 0) begin
            failures++;
            $display("FAIL illegal_op got err=%b data=%h lat=%0d beta_n=%0d exp 1 0 1 0", re, rd, lat, bn);
        end
    endtask

    task automatic test_full();
        int lat, bn, ba; logic [M-1:0] rd, bd; logic re;
        for (int i = 1; i <= 4; i++) begin
            do_req(2'b01, 32'(i), lat, rd, re, bn, ba, bd);
            model_q.push_back(32'(i));
        end
        checks++;
        if (full !== 1'b1 || count !== 3'd4) begin
            failures++;
            $display("FAIL fill got full=%b count=%0d exp 1 4", full, count);
        end
        do_req(2'b01, 32'h5, lat, rd, re, bn, ba, bd);
        checks++;
        if (re !== 1'b1 || rd !== '0 || lat !== 1 || bn !== 0 || count !== 3'd4 || mem_arr[3] !== 32'h4) begin
            failures++;
            $display("FAIL overflow got err=%b data=%h lat=%0d beta_n=%0d count=%0d mem3=%h exp 1 0 1 0 4 4",
                     re, rd, lat, bn, count, mem_arr[3]);
        end
        void'(model_q.pop_back());
        do_req(2'b10, '0, lat, rd, re, bn, ba, bd);
        checks++;
        if (rd !== 32'h4 || re !== 1'b0 || full !== 1'b0 || count !== 3'd3) begin
            failures++;
            $display("FAIL pop_full got data=%h err=%b full=%b count=%0d exp 4 0 0 3", rd, re, full, count);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_data = '0;
        @(posedge clock);
        #1 bus.req_valid = 1'b0; bus.req_op = 2'b00;
        @(negedge clock);
        if (bus.resp_valid === 1'b1) seen++;
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        model_q.delete();
        checks++;
        if (bus.req_ready !== 1'b1 || count !== 3'd0 || empty !== 1'b1 || mem_beta !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_state got rdy=%b count=%0d empty=%b beta=%b exp 1 0 1 0",
                     bus.req_ready, count, empty, mem_beta);
        end
        for (int i = 0; i < 6; i++) begin
            if (bus.resp_valid === 1'b1) seen++;
            @(negedge clock);
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_mid_resp got %0d response cycles exp 0", seen);
        end
    endtask

    task automatic test_random();
        int lat, bn, ba; logic [M-1:0] rd, bd; logic re;
        for (int t = 0; t < 60; t++) begin
            logic [1:0] op; logic [M-1:0] d;
            int e_lat, e_bn, e_ba; logic [M-1:0] e_rd, e_bd; logic e_err;
            op = 2'($urandom_range(0, 3));
            d  = $urandom;
            e_err = 1'b0; e_rd = '0; e_bn = 0; e_ba = -1; e_bd = '0; e_lat = 1;
            if (op == 2'b01 && model_q.size() < N) begin
                e_lat = 2; e_bn = 1; e_ba = model_q.size(); e_bd = d;
                model_q.push_back(d);
            end else if (op[1] == 1'b1 && model_q.size() > 0) begin
                e_rd = model_q[$];
                e_lat = WAIT + 1;
                if (op == 2'b10) begin
                    void'(model_q.pop_back());
                    e_lat = e_lat + SCRUB;
                    if (SCRUB == 1) begin e_bn = 1; e_ba = model_q.size(); end
                end
            end else begin
                e_err = 1'b1;
            end
            do_req(op, d, lat, rd, re, bn, ba, bd);
            checks++;
            if (lat !== e_lat || re !== e_err || rd !== e_rd || bn !== e_bn ||
                (e_bn == 1 && (ba !== e_ba || bd !== e_bd))) begin
                failures++;
                $display("FAIL rand_%0d op=%b got lat=%0d err=%b data=%h bn=%0d ba=%0d bd=%h exp lat=%0d err=%b data=%h bn=%0d ba=%0d bd=%h",
                         t, op, lat, re, rd, bn, ba, bd, e_lat, e_err, e_rd, e_bn, e_ba, e_bd);
            end
            @(negedge clock);
            checks++;
            if (int'(count) !== model_q.size() || full !== (model_q.size() == N) ||
                empty !== (model_q.size() == 0) || mem_beta !== 1'b0 || mem_in !== '0 ||
                int'(mem_ind1) !== (model_q.size() % N)) begin
                failures++;
                $display("FAIL rand_idle_%0d got count=%0d full=%b empty=%b beta=%b in=%h ind1=%0d exp count=%0d",
                         t, count, full, empty, mem_beta, mem_in, mem_ind1, model_q.size());
            end
        end
    endtask

`ifdef STACK_CTRL_SCRUB_EN
    task automatic test_scrub();
        int lat, bn, ba; logic [M-1:0] rd, bd; logic re;
        do_req(2'b01, 32'h55, lat, rd, re, bn, ba, bd);
        do_req(2'b10, '0, lat, rd, re, bn, ba, bd);
        checks++;
        if (rd !== 32'h55 || re !== 1'b0 || ba !== 0 || bd !== '0 || mem_arr[0] !== '0) begin
            failures++;
            $display("FAIL scrub got data=%h err=%b addr=%0d din=%h mem0=%h exp 55 0 0 0 0",
                     rd, re, ba, bd, mem_arr[0]);
        end
    endtask
`endif

    initial begin
        bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_data = '0;
        for (int i = 0; i < N; i++) mem_arr[i] = $urandom;
        test_reset();
        test_push();
        test_top_pop();
        test_empty_err();
        test_full();
        test_reset_mid();
        test_random();
`ifdef STACK_CTRL_SCRUB_EN
        test_reset();
        test_scrub();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
